alu_share_arbiter: RTL

Shares the single combinational `alu` instance between up to four requesters, such as the execute stage, the branch-compare unit and the address-generation path. Each requester uses a valid/ready request and response handshake. The block grants one request per accept cycle using round-robin priority and registers the ALU result and zero flag. It holds the response until the owning requester takes it, and it screens out function codes the ALU does not implement.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu.sv | 31 +++
 rtl/alu_share_arbiter_rr_pick.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: function codes, FSM state type
// and the legal-code screen.
package alu_arb_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SRL  = 5'd4;
  localparam logic [4:0] ALU_SRA  = 5'd5;
  localparam logic [4:0] ALU_SEQ  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_XOR  = 5'd9;
  localparam logic [4:0] ALU_OR   = 5'd10;
  localparam logic [4:0] ALU_AND  = 5'd11;

  typedef enum logic {IDLE, RESP} alu_arb_state_t;

  function automatic logic alu_func_legal(input logic [4:0] f);
    return (f >= ALU_ADD) && (f <= ALU_AND);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by the arbiter; unknown codes give 0.
module alu import alu_arb_pkg::*; (
  input  logic [4:0]  func_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // Shift amount is the full 32-bit B: shifts of 32 or more flush the word.
  always_comb begin
    result_o = '0;
    case (func_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << b_i;
      ALU_SRL:  result_o = a_i >> b_i;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i);
      ALU_SEQ:  result_o = {31'd0, a_i == b_i};
      ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Requester picker: round-robin after last_grant, or lowest-index-wins when
// ALU_ARB_FIXED_PRIO_EN is defined.
module rr_pick import alu_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]      last_grant_i,
`endif
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IW-1:0]      gnt_idx_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Walk downward so the lowest requesting index is the last write.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = IW'(k);
      end
    end
  end
`else
  int idx;

  // Walk distance NUM_REQ down to 1 from last_grant; the nearest requester wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ valid/ready requesters and registers the result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_share_arbiter import alu_arb_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][4:0]  req_func,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [31:0]              resp_result,
  output logic                     resp_zero,
  output logic                     resp_err,
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  alu_arb_state_t     state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [31:0]        result_q, result_d;
  logic               zero_q, zero_d, err_q, err_d;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;
  logic [4:0]         sel_func, alu_func;
  logic [31:0]        alu_a, alu_b, alu_res;
  logic               alu_zero, any_gnt, legal, resp_done, accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last_q, last_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i        (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .last_grant_i (last_q),
`endif
    .gnt_oh_o     (gnt_oh),
    .gnt_idx_o    (gnt_idx)
  );

  assign any_gnt  = |gnt_oh;
  assign sel_func = req_func[gnt_idx];
  assign legal    = alu_func_legal(sel_func);

  // Illegal or absent requests feed ADD 0,0 so nothing stale reaches the ALU.
  assign alu_func = (any_gnt && legal) ? sel_func         : ALU_ADD;
  assign alu_a    = (any_gnt && legal) ? req_a[gnt_idx]   : '0;
  assign alu_b    = (any_gnt && legal) ? req_b[gnt_idx]   : '0;

  alu u_alu (
    .func_i   (alu_func),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  assign resp_done = (state_q == RESP) && resp_ready[owner_q];
  assign accept    = !reset && any_gnt && ((state_q == IDLE) || resp_done);
  assign req_ready = accept ? gnt_oh : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    if (accept) begin
      state_d  = RESP;
      owner_d  = gnt_idx;
      result_d = legal ? alu_res : '0;
      zero_d   = legal && alu_zero;
      err_d    = !legal;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_d   = gnt_idx;
`endif
    end else if (resp_done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= IW'(NUM_REQ-1);
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = (state_q == RESP) && (owner_q == IW'(i));
  end

  assign busy        = (state_q == RESP);
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;

endmodule
